// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a byte FIFO with a registered read port.
// Frame: start, 8 data bits LSB-first, optional parity, one stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [15:0]     frames_q, frames_d;
    logic            tx_q, tx_d;
    logic            bit_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            frames_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            frames_q <= frames_d;
            tx_q     <= tx_d;
        end
    end

    assign bit_done = (cnt_q == CntMax);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        frames_d = frames_q;
        unique case (state_q)
            StIdle: begin
                if (enable && !fifo_empty) state_d = StReq;
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                // Registered FIFO output is only valid in this cycle.
                shift_d  = fifo_data;
                parity_d = (^fifo_data) ^ PARITY_ODD;
                bit_d    = '0;
                state_d  = StStart;
            end
            StStart: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
                if (bit_done) state_d = StData;
            end
            StData: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY_EN ? StParity : StStop;
                end
            end
            StParity: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
                if (bit_done) state_d = StStop;
            end
            StStop: begin
                cnt_d = bit_done ? '0 : cnt_q + 1'b1;
                if (bit_done) begin
                    frames_d = frames_q + 16'd1;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // tx_d is the line level for the current state; registering it delays the
    // whole frame by one cycle but keeps every bit exactly CLKS_PER_BIT long.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
            StParity: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
        fifo_rd_en = (state_q == StReq);
        busy       = (state_q != StIdle);
    end

    assign tx          = tx_q;
    assign frames_sent = frames_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-deep byte FIFO: pops one byte at a time and serialises it as an asynchronous UART frame on `tx`.
- Frame format: start bit, 8 data bits LSB-first, optional parity bit, one stop bit.
- Handles the FIFO's registered read port: data is valid one cycle after the read-enable pulse.
- Sits between the FIFO read side and the board TX pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥ 2.
- PARITY_EN, 0, 1 = insert a parity bit after bit 7.
- PARITY_ODD, 0, when PARITY_EN=1: 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  1 = allowed to start new frames.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO registered data_out.
- fifo_rd_en  output  1  one-cycle pop request to FIFO.
- tx  output  1  serial line, idle high.
- busy  output  1  1 whenever state != IDLE.
- frames_sent  output  16  count of completed frames, wraps at 0xFFFF→0.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces:
  - state=IDLE, tx=1, fifo_rd_en=0, busy=0, frames_sent=0
  - baud counter, bit index and shift register = 0
- Reset overrides everything, including a frame in progress. The frame is truncated with tx high from the next cycle, and no further FIFO pop occurs.
- The bit index is 0..7. The baud counter needs clog2(CLKS_PER_BIT) bits.
- tx is a registered output. Internally, fifo_rd_en and busy are decodes of state.
- FSM states: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
  - IDLE:
    - tx=1.
    - If enable=1 and fifo_empty=0, go to REQ; otherwise stay.
  - REQ:
    - fifo_rd_en=1 for exactly this one cycle.
    - Next state: WAIT.
  - WAIT:
    - fifo_data is valid this cycle; latch it into the shift register at the end of the cycle.
    - Compute the parity bit from the latched byte.
    - Next state: START.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA:
    - tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
    - After the 8th bit, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY:
    - tx = (^byte) XOR PARITY_ODD for CLKS_PER_BIT cycles.
    - Next state: STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - On the final cycle, increment frames_sent and go to IDLE.
- Bit-time alignment:
  - The baud counter resets to 0 on every state entry.
  - Each bit lasts exactly CLKS_PER_BIT cycles measured on tx.
  - tx changes exactly at bit boundaries.
- Frame length on tx: 10×CLKS_PER_BIT cycles (11× with parity).
- Minimum gap between back-to-back frames: 3 idle-high cycles (IDLE, REQ, WAIT) after the stop bit.
- fifo_empty and enable are sampled only in IDLE.
  - Deasserting enable mid-frame does not abort the frame; the current frame completes.
  - No new pop occurs while enable=0.
- fifo_rd_en is never asserted while fifo_empty=1. This block is the FIFO's sole reader, so empty cannot rise between IDLE and REQ.
- Exactly one fifo_rd_en pulse per transmitted frame.
- fifo_data changes outside WAIT are ignored.

Test Plan:
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0:
  - Stimulus: FIFO holds 0xA5, enable=1.
  - Required: one fifo_rd_en pulse; tx shows 0, 1,0,1,0,0,1,0,1, 1, each level lasting 4 cycles (40 cycles total); frames_sent=1; busy=0 afterwards.
- Back-to-back:
  - Stimulus: FIFO preloaded with 0x00, 0xFF, 0x3C, enable=1.
  - Required: three frames in order, each separated by exactly 3 high cycles; 3 rd_en pulses; fifo_words reaches 0; frames_sent=3; then IDLE with tx=1.
- Parity, CLKS_PER_BIT=4:
  - PARITY_EN=1, PARITY_ODD=0, byte 0x07: parity bit=1, frame 44 cycles.
  - PARITY_ODD=1, same byte: parity bit=0.
- Empty and enable gating:
  - FIFO empty with enable=1 for 100 cycles: no rd_en, tx=1, busy=0.
  - enable=0 with 2 bytes queued: no pops.
  - enable dropped during DATA of frame 1: frame 1 completes, frame 2 is not started.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 for 1 cycle during DATA bit 3 of 0x55.
  - Required: next cycle tx=1, busy=0, frames_sent=0; after release with FIFO non-empty, the next byte is transmitted as a complete frame.
- Counter wrap:
  - Stimulus: force frames_sent near 0xFFFF via 2 frames from a preset (or a long run).
  - Required: 0xFFFF→0x0000 rollover, with no effect on tx.
